// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the MSI snooping bus: request kinds, controller states, line index width.
package coherence_bus_ctrl_pkg;

    localparam int BOCI_W = 11;

    typedef enum logic [1:0] {BR_NONE, BR_RM, BR_WM, BR_INV} bus_req_t;

    typedef enum logic [2:0] {IDLE, SNOOP, MEM_RD, FLUSH, GRANT} bus_state_t;

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Snooping bus bundle between the cache controllers / memory and the bus controller.
// master = bus controller, slave = caches and unified memory.
interface coherence_bus_ctrl_if #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 11,
    localparam int OW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
);
    logic [NUM_CORES-1:0]        req_rm;
    logic [NUM_CORES-1:0]        req_wm;
    logic [NUM_CORES-1:0]        req_inv;
    logic [NUM_CORES*ADDR_W-1:0] req_addr;
    logic [NUM_CORES-1:0]        snoop_found;
    logic [NUM_CORES*DATA_W-1:0] snoop_data;
    logic                        mem_rdy;
    logic [DATA_W-1:0]           mem_rdata;
    logic [NUM_CORES-1:0]        grant;
    logic [DATA_W-1:0]           bus_data;
    logic [IDX_W-1:0]            boci;
    logic [NUM_CORES-1:0]        snoop_search;
    logic [NUM_CORES-1:0]        snoop_inv;
    logic                        mem_re;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        bus_busy;
    logic [OW-1:0]               bus_owner;

    modport master (
        input  req_rm, req_wm, req_inv, req_addr, snoop_found, snoop_data, mem_rdy, mem_rdata,
        output grant, bus_data, boci, snoop_search, snoop_inv, mem_re, mem_we, mem_addr,
               mem_wdata, bus_busy, bus_owner
    );

    modport slave (
        output req_rm, req_wm, req_inv, req_addr, snoop_found, snoop_data, mem_rdy, mem_rdata,
        input  grant, bus_data, boci, snoop_search, snoop_inv, mem_re, mem_we, mem_addr,
               mem_wdata, bus_busy, bus_owner
    );

endinterface

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first pending core above last_owner, wrapping.
// Zero latency; no backpressure (parent samples the result only in IDLE).
module coherence_bus_ctrl_rr_arbiter #(
    parameter int NUM_CORES = 2,
    localparam int OW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] pending,
    input  logic [OW-1:0]        last_owner,
    output logic [NUM_CORES-1:0] win_oh,
    output logic [OW-1:0]        win_idx,
    output logic                 any_vld
);

    int cand;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any_vld = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = int'(last_owner) + i;
            if (cand >= NUM_CORES) cand = cand - NUM_CORES;
            for (int j = 0; j < NUM_CORES; j++) begin
                if (j == cand && !any_vld && pending[j]) begin
                    any_vld   = 1'b1;
                    win_idx   = OW'(j);
                    win_oh[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// MSI snooping bus controller: round-robin arbitration, snoop broadcast, peer/memory sourcing.
// Grant 2 cycles after the IDLE sample (peer/invalidate) or 2+k (memory/flush); mem_rdy stalls.
module coherence_bus_ctrl
    import coherence_bus_ctrl_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = BOCI_W,
    localparam int OW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input logic               clk,
    input logic               rst_n,
    coherence_bus_ctrl_if.master bus
);

    bus_state_t           state_q, state_d;
    bus_req_t             kind_q, kind_d, kind_sel;
    logic [OW-1:0]        owner_q, owner_d, last_owner_q, last_owner_d, win_idx;
    logic [ADDR_W-1:0]    addr_q, addr_d, addr_sel;
    logic [DATA_W-1:0]    bus_data_q, bus_data_d, mem_wdata_q, mem_wdata_d, peer_dat;
    logic [IDX_W-1:0]     boci_q, boci_d;
    logic [NUM_CORES-1:0] grant_q, grant_d, search_q, search_d, inv_q, inv_d;
    logic [NUM_CORES-1:0] win_oh, owner_oh;
    logic                 mem_re_q, mem_re_d, mem_we_q, mem_we_d, any_vld, peer_vld;

    coherence_bus_ctrl_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .pending    (bus.req_rm | bus.req_wm | bus.req_inv),
        .last_owner (last_owner_q),
        .win_oh     (win_oh),
        .win_idx    (win_idx),
        .any_vld    (any_vld)
    );

    always_comb begin
        addr_sel = '0;
        kind_sel = BR_NONE;
        for (int j = 0; j < NUM_CORES; j++) begin
            if (win_oh[j]) begin
                addr_sel = bus.req_addr[j*ADDR_W +: ADDR_W];
                if (bus.req_wm[j])       kind_sel = BR_WM;
                else if (bus.req_inv[j]) kind_sel = BR_INV;
                else                     kind_sel = BR_RM;
            end
        end
    end

    // Descending scan so the lowest-index non-owner responder supplies the word.
    always_comb begin
        peer_vld = 1'b0;
        peer_dat = '0;
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            if (bus.snoop_found[j] && OW'(j) != owner_q) begin
                peer_vld = 1'b1;
                peer_dat = bus.snoop_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        bus_data_d   = bus_data_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: if (any_vld) begin
                owner_d = win_idx;
                addr_d  = addr_sel;
                kind_d  = kind_sel;
                state_d = SNOOP;
            end
            SNOOP: begin
                if (kind_q == BR_INV) begin
                    state_d = GRANT;
                end else if (peer_vld) begin
                    bus_data_d = peer_dat;
                    if (kind_q == BR_RM) begin
                        mem_wdata_d = peer_dat;
                        state_d     = FLUSH;
                    end else begin
                        state_d = GRANT;
                    end
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: if (bus.mem_rdy) begin
                bus_data_d = bus.mem_rdata;
                state_d    = GRANT;
            end
            FLUSH: if (bus.mem_rdy) state_d = GRANT;
            GRANT: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so they are registered yet align with it.
        owner_oh = NUM_CORES'(1) << owner_d;
        boci_d   = (state_d == SNOOP) ? IDX_W'(addr_d >> 2) : boci_q;
        search_d = (state_d == SNOOP) ? ~owner_oh : '0;
        inv_d    = (state_d == SNOOP && kind_d != BR_RM) ? ~owner_oh : '0;
        mem_re_d = (state_d == MEM_RD);
        mem_we_d = (state_d == FLUSH);
        grant_d  = (state_d == GRANT) ? owner_oh : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            kind_q       <= BR_NONE;
            owner_q      <= OW'(NUM_CORES - 1);
            last_owner_q <= OW'(NUM_CORES - 1);
            addr_q       <= '0;
            bus_data_q   <= '0;
            mem_wdata_q  <= '0;
            boci_q       <= '0;
            grant_q      <= '0;
            search_q     <= '0;
            inv_q        <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            bus_data_q   <= bus_data_d;
            mem_wdata_q  <= mem_wdata_d;
            boci_q       <= boci_d;
            grant_q      <= grant_d;
            search_q     <= search_d;
            inv_q        <= inv_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.bus_data     = bus_data_q;
    assign bus.boci         = boci_q;
    assign bus.snoop_search = search_q;
    assign bus.snoop_inv    = inv_q;
    assign bus.mem_re       = mem_re_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.bus_busy     = (state_q != IDLE);
    assign bus.bus_owner    = owner_q;

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Shared snooping bus for the MSI data caches; sits directly downstream of each core's cache controller.
- Consumes each controller's read_miss / write_miss / invalidate requests and arbitrates among cores round-robin.
- Broadcasts the line index (BOCI) plus search/invalidate strobes to the other caches.
- Sources the line word from a peer cache or from unified memory, then returns it with a one-cycle grant pulse to the requester.

Parameters:
- NUM_CORES, 2, number of attached cache controllers (at least 2).
- ADDR_W, 13, word address width.
- DATA_W, 16, bus data width.
- IDX_W, 11, line index width; BOCI = addr[ADDR_W-1:2].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_rm  in  NUM_CORES  per-core read miss, level, held until grant
- req_wm  in  NUM_CORES  per-core write miss, level, held until grant
- req_inv  in  NUM_CORES  per-core invalidate (SHARED->MODIFIED upgrade), level
- req_addr  in  NUM_CORES*ADDR_W  per-core word address, core i in slice i
- snoop_found  in  NUM_CORES  peer holds a valid copy of boci; combinational response in the same cycle
- snoop_data  in  NUM_CORES*DATA_W  peer's word at boci[1:0]-selected offset (send_other_proc_data)
- mem_rdy  in  1  unified memory access complete
- mem_rdata  in  DATA_W  unified memory read data
- grant  out  NUM_CORES  one-hot, one-cycle completion pulse
- bus_data  out  DATA_W  captured line word; valid on grant and held afterwards
- boci  out  IDX_W  broadcast line index
- snoop_search  out  NUM_CORES  search strobe to non-owner cores
- snoop_inv  out  NUM_CORES  invalidate strobe to non-owner cores
- mem_re  out  1  memory read request
- mem_we  out  1  memory write request (flush)
- mem_addr  out  ADDR_W  memory address (latched request address)
- mem_wdata  out  DATA_W  flush data
- bus_busy  out  1  state != IDLE
- bus_owner  out  $clog2(NUM_CORES)  current or last winner index

Behaviour:
- Reset:
  - state = IDLE; all strobes, grant, mem_re, mem_we = 0.
  - bus_data, boci, mem_addr, mem_wdata = 0.
  - last_owner = NUM_CORES-1, so core 0 wins first.
- State IDLE:
  - A core is pending if any of its req bits is set.
  - Winner is the first pending core searching upward from last_owner+1, with wrap-around.
  - Latch owner, address and kind. Kind priority within one core: WM > INV > RM.
  - Go to SNOOP. With no request, stay in IDLE.
- State SNOOP (exactly 1 cycle):
  - boci = addr[12:2]; snoop_search[j] = 1 for every j != owner.
  - snoop_inv[j] = 1 for j != owner when kind is WM or INV.
  - At the clock edge:
    - INV goes to GRANT; bus_data is left unchanged.
    - Otherwise, if any peer reports found, capture snoop_data of the lowest-index found peer. RM then goes to FLUSH; WM goes to GRANT.
    - If no peer reports found, go to MEM_RD.
- State MEM_RD:
  - mem_re = 1, mem_addr = latched addr, held until mem_rdy.
  - On mem_rdy: capture mem_rdata and go to GRANT.
- State FLUSH:
  - mem_we = 1, mem_wdata = captured peer data, held until mem_rdy, then go to GRANT.
  - Purpose: the peer's MODIFIED line becomes SHARED and clean.
- State GRANT (1 cycle):
  - grant[owner] = 1; last_owner <= owner; go to IDLE.
- Latency from the request sampled in IDLE:
  - INV and peer-supplied WM: grant in cycle +2.
  - Memory or flush path: grant in cycle +2+k, where k (at least 1) is the number of cycles until mem_rdy.
- There is a mandatory IDLE cycle between transactions. A request still high during the grant cycle is not re-arbitrated until the following IDLE cycle.
- Requester deasserts mid-transaction: the transaction still completes and grant still pulses.
- Multiple peers found: the lowest index supplies data; all peers still see the strobes.
- mem_rdy asserted while not in MEM_RD or FLUSH: ignored.
- Owner's own snoop_found and snoop_data: ignored.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. No grant is issued.

Decomposition:
- Shared package additions:
  - bus_req_t enum {BR_NONE, BR_RM, BR_WM, BR_INV}.
  - bus_state_t enum {IDLE, SNOOP, MEM_RD, FLUSH, GRANT}.
  - Constant BOCI_W = 11.
- Sub-module rr_arbiter (NUM_CORES parameter):
  - Inputs: pending vector, last_owner.
  - Outputs: one-hot winner, winner index, any_valid.
  - Purely combinational; the last_owner register lives in the parent.

Test Plan:
- After reset, core0 req_rm with addr 0x0104, no peer found, mem_rdy on the 3rd MEM_RD cycle, mem_rdata 0xBEEF -> mem_re held 3 cycles, mem_addr 0x0104, boci 0x041 in SNOOP, grant[0] pulses and bus_data = 0xBEEF.
- Core1 req_wm addr 0x1FFF, core0 found with snoop_data 0x1234 -> SNOOP asserts snoop_search[0] and snoop_inv[0], no mem access, grant[1] 2 cycles after request, bus_data = 0x1234.
- Core0 req_rm, core1 found with 0xA5A5, mem_rdy after 2 cycles -> FLUSH mem_we with mem_wdata 0xA5A5 for 2 cycles, then grant[0] with bus_data 0xA5A5.
- Core0 and core1 both request every cycle continuously -> grants alternate 0, 1, 0, 1; starvation-free.
- Core1 req_inv -> snoop_inv[0] for exactly 1 cycle, grant[1] next cycle, mem_re and mem_we never asserted, bus_data unchanged.
- Assert rst_n low during MEM_RD -> mem_re drops asynchronously, no grant, bus_busy 0; after release core0 wins first.
